// File: rtl/multi_debouncer.sv
//------------------------------------------------------------------------------
// multi_debouncer
//
// Debounces NUM_CH asynchronous mechanical button/switch pins. Each channel
// has its own synchroniser and four-state debounce FSM that filters both
// press and release. Optional auto-repeat re-issues press pulses while a
// button stays held.
//
// Parameters
//   NUM_CH          number of independent channels (>= 1)
//   DEBOUNCE_CYCLES consecutive stable samples needed to accept an edge (>= 1)
//   SYNC_STAGES     synchroniser depth per channel (>= 2)
//   ACTIVE_LOW      1: pin low = pressed, 0: pin high = pressed
//   REPEAT_CYCLES   auto-repeat period while held, 0 disables auto-repeat
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   noisy_in       raw button pins, bit i = channel i
//   clean_level    registered debounced level, 1 = pressed
//   press_pulse    one-cycle pulse per accepted press and per auto-repeat
//   release_pulse  one-cycle pulse per accepted release
//   any_press      OR of press_pulse bits, aligned with press_pulse
//------------------------------------------------------------------------------
module multi_debouncer #(
   parameter int NUM_CH          = 4,
   parameter int DEBOUNCE_CYCLES = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int ACTIVE_LOW      = 1,
   parameter int REPEAT_CYCLES   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] noisy_in,
   output logic [NUM_CH-1:0] clean_level,
   output logic [NUM_CH-1:0] press_pulse,
   output logic [NUM_CH-1:0] release_pulse,
   output logic              any_press
);

   // Counter must reach the larger of the debounce and repeat terminal counts.
   localparam int MAX_DR   = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CNT_SPAN = (MAX_DR > 2) ? MAX_DR : 2;
   localparam int CW       = $clog2(CNT_SPAN);

   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RPT_LAST = (REPEAT_CYCLES > 0) ? CW'(REPEAT_CYCLES - 1) : '0;
   localparam logic          RPT_EN   = (REPEAT_CYCLES > 0);

   // Pin level that means "not pressed"; also the synchroniser reset value so
   // a pin already held at reset release still sees the full press latency.
   localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      RELEASED,
      DB_PRESS,
      HELD,
      DB_RELEASE
   } db_state_t;

   // Per-channel "press pulse fires on the next edge"; shared so any_press can
   // be registered on the same edge as the individual pulse bits.
   logic [NUM_CH-1:0] press_evt;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   active;
      db_state_t              state;
      logic [CW-1:0]          cnt;
      logic                   level_q;
      logic                   press_q;
      logic                   release_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sync_q <= {SYNC_STAGES{PIN_IDLE}};
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in[i]};
         end
      end

      assign active = sync_q[SYNC_STAGES-1] ^ PIN_IDLE;

      assign press_evt[i] = active &&
                            (((state == DB_PRESS) && (cnt == DB_LAST)) ||
                             (RPT_EN && (state == HELD) && (cnt == RPT_LAST)));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state     <= RELEASED;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= press_evt[i];
            release_q <= 1'b0;
            case (state)
               RELEASED: begin
                  if (active) begin
                     state <= DB_PRESS;
                     cnt   <= '0;
                  end
               end

               DB_PRESS: begin
                  if (!active) begin
                     state <= RELEASED;
                     cnt   <= '0;
                  end else if (cnt == DB_LAST) begin
                     state   <= HELD;
                     cnt     <= '0;
                     level_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end

               HELD: begin
                  if (!active) begin
                     state <= DB_RELEASE;
                     cnt   <= '0;
                  end else if (RPT_EN) begin
                     // Repeat phase: wraps to 0 exactly when a repeat pulse fires.
                     if (cnt == RPT_LAST) begin
                        cnt <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     cnt <= '0;
                  end
               end

               DB_RELEASE: begin
                  if (active) begin
                     // Bounce back to held restarts the repeat phase from zero.
                     state <= HELD;
                     cnt   <= '0;
                  end else if (cnt == DB_LAST) begin
                     state     <= RELEASED;
                     cnt       <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end

               default: begin
                  state <= RELEASED;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign clean_level[i]   = level_q;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         any_press <= 1'b0;
      end else begin
         any_press <= |press_evt;
      end
   end

endmodule
